// File: rtl/pipeline_step_ctrl.sv
// Pipeline step controller: run / single-step / halt sequencing
// for the pipeline latch enables, with a saturating cycle counter.
module pipeline_step_ctrl #(
    parameter int BITS_SIZE  = 32,
    parameter int BITS_STEPS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    input  logic [1:0]            i_cmd,
    input  logic [BITS_STEPS-1:0] i_step_count,
    input  logic                  i_halt,
    output logic                  o_cmd_ready,
    output logic                  o_step,
    output logic                  o_flush,
    output logic                  o_done,
    output logic                  o_cmd_err,
    output logic [1:0]            o_state,
    output logic [BITS_SIZE-1:0]  o_cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [BITS_STEPS-1:0] STEP_ONE = BITS_STEPS'(1);
    localparam logic [BITS_SIZE-1:0]  CNT_ONE  = BITS_SIZE'(1);

    state_t                state;
    state_t                state_nxt;
    logic [BITS_STEPS-1:0] remaining;
    logic [BITS_STEPS-1:0] remaining_nxt;
    logic                  flush_nxt;
    logic                  err_nxt;
    logic                  accept;

    assign o_cmd_ready = (state != S_STEP);
    assign o_step      = ((state == S_RUN) || (state == S_STEP)) && !i_halt;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign o_state     = state;

    // Next state, step budget and one-shot flush/error requests
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        flush_nxt     = 1'b0;
        err_nxt       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (i_cmd)
                        CMD_RUN:   state_nxt = S_RUN;
                        CMD_STEP: begin
                            state_nxt     = S_STEP;
                            remaining_nxt = (i_step_count == '0) ?
                                            STEP_ONE : i_step_count;
                        end
                        CMD_CLEAR: flush_nxt = 1'b1;
                        default:   err_nxt   = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                // Any accepted non-STOP command is still reported
                // as illegal, even when halt wins the transition.
                if (accept && (i_cmd != CMD_STOP))
                    err_nxt = 1'b1;
                if (i_halt)
                    state_nxt = S_HALTED;
                else if (accept && (i_cmd == CMD_STOP))
                    state_nxt = S_IDLE;
            end
            S_STEP: begin
                if (i_halt) begin
                    state_nxt     = S_HALTED;
                    remaining_nxt = '0;
                end else begin
                    remaining_nxt = remaining - STEP_ONE;
                    if (remaining == STEP_ONE)
                        state_nxt = S_IDLE;
                end
            end
            S_HALTED: begin
                if (accept) begin
                    if (i_cmd == CMD_CLEAR) begin
                        state_nxt = S_IDLE;
                        flush_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, step budget and registered one-cycle pulses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            o_flush   <= 1'b0;
            o_done    <= 1'b0;
            o_cmd_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            o_flush   <= flush_nxt;
            o_done    <= (state == S_STEP) && (state_nxt != S_STEP);
            o_cmd_err <= err_nxt;
        end
    end

    // Saturating count of advance cycles, zeroed by a legal CLEAR
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_cycle_count <= '0;
        else if (flush_nxt)
            o_cycle_count <= '0;
        else if (o_step && (o_cycle_count != '1))
            o_cycle_count <= o_cycle_count + CNT_ONE;
    end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Bench for pipeline_step_ctrl: directed scenarios plus random
// command traffic checked cycle by cycle against a mode model.
module tb_pipeline_step_ctrl;

    localparam int BW   = 6;
    localparam int SW   = 8;
    localparam int CMAX = (1 << BW) - 1;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic [1:0]    i_cmd = 2'b00;
    logic [SW-1:0] i_step_count = '0;
    logic          i_halt = 1'b0;
    logic          o_cmd_ready;
    logic          o_step;
    logic          o_flush;
    logic          o_done;
    logic          o_cmd_err;
    logic [1:0]    o_state;
    logic [BW-1:0] o_cycle_count;

    pipeline_step_ctrl #(.BITS_SIZE(BW), .BITS_STEPS(SW)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid),
        .i_cmd(i_cmd),
        .i_step_count(i_step_count),
        .i_halt(i_halt),
        .o_cmd_ready(o_cmd_ready),
        .o_step(o_step),
        .o_flush(o_flush),
        .o_done(o_done),
        .o_cmd_err(o_cmd_err),
        .o_state(o_state),
        .o_cycle_count(o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    // model modes follow the visible o_state codes
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
    localparam int C_RUN = 0, C_STEP = 1, C_STOP = 2, C_CLEAR = 3;

    int total = 0;
    int bad = 0;
    int m_mode = M_IDLE;
    int m_left = 0;
    int m_cnt = 0;
    bit m_flush = 0, m_done = 0, m_err = 0;
    int n_step = 0, n_busy = 0, n_done = 0;
    bit last_step = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_left = 0;
        m_cnt = 0;
        m_flush = 0;
        m_done = 0;
        m_err = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".state"}, 64'(o_state), 64'(m_mode));
        chk({tag, ".count"}, 64'(o_cycle_count), 64'(m_cnt));
        chk({tag, ".flush"}, 64'(o_flush), 64'(m_flush));
        chk({tag, ".done"}, 64'(o_done), 64'(m_done));
        chk({tag, ".err"}, 64'(o_cmd_err), 64'(m_err));
    endtask

    // One clock: drive, check combinational outputs, clock, check regs
    task automatic cycle(input bit v, input int c, input int n,
                         input bit h);
        bit acc, adv;
        int old_mode;
        @(negedge i_clk);
        i_cmd_valid = v;
        i_cmd = 2'(c);
        i_step_count = SW'(n);
        i_halt = h;
        #1;
        acc = v && (m_mode != M_STEP);
        adv = (m_mode == M_RUN || m_mode == M_STEP) && !h;
        chk("ready", 64'(o_cmd_ready), 64'(m_mode != M_STEP));
        chk("step", 64'(o_step), 64'(adv));
        last_step = o_step;
        if (o_step) n_step++;
        if (!o_cmd_ready) n_busy++;
        old_mode = m_mode;
        m_flush = 0;
        m_err = 0;
        if (m_mode == M_IDLE) begin
            if (acc) begin
                if (c == C_RUN) m_mode = M_RUN;
                else if (c == C_STEP) begin
                    m_mode = M_STEP;
                    m_left = (n == 0) ? 1 : n;
                end else if (c == C_CLEAR) m_flush = 1;
                else m_err = 1;
            end
        end else if (m_mode == M_RUN) begin
            if (acc && c != C_STOP) m_err = 1;
            if (h) m_mode = M_HALT;
            else if (acc && c == C_STOP) m_mode = M_IDLE;
        end else if (m_mode == M_STEP) begin
            if (h) begin
                m_mode = M_HALT;
                m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = M_IDLE;
            end
        end else begin
            if (acc) begin
                if (c == C_CLEAR) begin
                    m_mode = M_IDLE;
                    m_flush = 1;
                end else m_err = 1;
            end
        end
        m_done = (old_mode == M_STEP) && (m_mode != M_STEP);
        if (m_flush) m_cnt = 0;
        else if (adv && m_cnt < CMAX) m_cnt++;
        @(posedge i_clk);
        #1;
        if (o_done) n_done++;
        check_regs("cyc");
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic clr_counters();
        n_step = 0;
        n_busy = 0;
        n_done = 0;
    endtask

    initial begin
        int c, n;
        bit v, h;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.ready", 64'(o_cmd_ready), 64'd1);
        chk("rst.step", 64'(o_step), 64'd0);
        check_regs("rst");
        @(negedge i_clk);
        i_reset = 1'b0;

        // RUN for 5 advance cycles, then STOP
        clr_counters();
        cycle(1, C_RUN, 0, 0);
        idle(4);
        cycle(1, C_STOP, 0, 0);
        chk("run5.steps", 64'(n_step), 64'd5);
        chk("run5.count", 64'(o_cycle_count), 64'd5);
        chk("run5.state", 64'(o_state), 64'd0);

        // STEP 3
        cycle(1, C_CLEAR, 0, 0);
        chk("clr.flush", 64'(o_flush), 64'd1);
        clr_counters();
        cycle(1, C_STEP, 3, 0);
        idle(3);
        chk("step3.steps", 64'(n_step), 64'd3);
        chk("step3.busy", 64'(n_busy), 64'd3);
        chk("step3.done", 64'(n_done), 64'd1);
        chk("step3.state", 64'(o_state), 64'd0);
        chk("step3.count", 64'(o_cycle_count), 64'd3);
        idle(1);

        // STEP 0 behaves as STEP 1
        clr_counters();
        cycle(1, C_STEP, 0, 0);
        idle(2);
        chk("step0.steps", 64'(n_step), 64'd1);
        chk("step0.done", 64'(n_done), 64'd1);

        // halt beats STOP; HALTED rejects RUN; CLEAR recovers
        cycle(1, C_RUN, 0, 0);
        idle(1);
        cycle(1, C_STOP, 0, 1);
        chk("halt.step", 64'(last_step), 64'd0);
        chk("halt.state", 64'(o_state), 64'd3);
        cycle(1, C_RUN, 0, 0);
        chk("halt.err", 64'(o_cmd_err), 64'd1);
        chk("halt.stay", 64'(o_state), 64'd3);
        cycle(1, C_CLEAR, 0, 0);
        chk("halt.flush", 64'(o_flush), 64'd1);
        chk("halt.cnt0", 64'(o_cycle_count), 64'd0);
        chk("halt.idle", 64'(o_state), 64'd0);
        idle(1);
        chk("halt.flush1", 64'(o_flush), 64'd0);

        // STEP 10 halted after 4 advances
        clr_counters();
        cycle(1, C_STEP, 10, 0);
        idle(4);
        cycle(0, 0, 0, 1);
        chk("sh.state", 64'(o_state), 64'd3);
        chk("sh.done", 64'(n_done), 64'd1);
        chk("sh.count", 64'(o_cycle_count), 64'd4);
        cycle(1, C_CLEAR, 0, 0);

        // counter saturates instead of wrapping
        cycle(1, C_RUN, 0, 0);
        idle(CMAX + 6);
        chk("sat.count", 64'(o_cycle_count), 64'(CMAX));
        cycle(1, C_STOP, 0, 0);

        // asynchronous reset in the middle of a STEP
        clr_counters();
        cycle(1, C_STEP, 10, 0);
        idle(2);
        @(negedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        model_reset();
        chk("ar.state", 64'(o_state), 64'd0);
        chk("ar.step", 64'(o_step), 64'd0);
        chk("ar.ready", 64'(o_cmd_ready), 64'd1);
        chk("ar.count", 64'(o_cycle_count), 64'd0);
        chk("ar.done", 64'(o_done), 64'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        idle(3);
        chk("ar.nodone", 64'(n_done), 64'd0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 2) != 0);
            c = $urandom_range(0, 3);
            n = $urandom_range(0, 6);
            h = ($urandom_range(0, 9) == 0);
            cycle(v, c, n, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
